// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared defaults, flag bundle and count helper for FIFO    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

  localparam int FIFO_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int FIFO_ADDRESS = 4;
  localparam int FIFO_PTR_W   = FIFO_ADDRESS + 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int unsigned next_count(input int unsigned cnt,
                                             input logic        inc,
                                             input logic        dec);
    return cnt + 32'(inc) - 32'(dec);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl_dp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ctrl_dp_if : producer/consumer stream, status and RAM port      |
// | Optional overflow/underflow under FIFO_ERR_FLAG_EN. Rev 1.0          |
// +----------------------------------------------------------------------+
interface fifo_ctrl_dp_if
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int ADDRESS = FIFO_ADDRESS
);
  logic               push;
  logic [WIDTH-1:0]   push_data;
  logic               push_ready;
  logic               pop;
  logic [WIDTH-1:0]   pop_data;
  logic               pop_valid;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [ADDRESS:0]   count;
  logic               ram_wr_en;
  logic [ADDRESS-1:0] ram_wr_addr;
  logic [WIDTH-1:0]   ram_wr_data;
  logic               ram_rd_en;
  logic [ADDRESS-1:0] ram_rd_addr;
  logic [WIDTH-1:0]   ram_rd_data;
`ifdef FIFO_ERR_FLAG_EN
  logic               overflow;
  logic               underflow;
`endif

  modport master (
    output push, push_data, pop, ram_rd_data,
`ifdef FIFO_ERR_FLAG_EN
    input  overflow, underflow,
`endif
    input  push_ready, pop_data, pop_valid, full, empty, almost_full,
           almost_empty, count, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_en, ram_rd_addr
  );

  modport slave (
    input  push, push_data, pop, ram_rd_data,
`ifdef FIFO_ERR_FLAG_EN
    output overflow, underflow,
`endif
    output push_ready, pop_data, pop_valid, full, empty, almost_full,
           almost_empty, count, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_en, ram_rd_addr
  );

endinterface
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ptr : W-bit wrap counter with increment enable, async reset     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_PTR_W
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_en,
  output logic [W-1:0]      o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl_dp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ctrl_dp : push/pop FIFO controller driving ram_dp_sync ports    |
// | Option macro: FIFO_ERR_FLAG_EN (sticky overflow/underflow). Rev 1.0  |
// +----------------------------------------------------------------------+
module fifo_ctrl_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDRESS  = FIFO_ADDRESS,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  wire logic     clock,
  input  wire logic     reset,
  fifo_ctrl_dp_if.slave bus
);

  localparam int c_ptr_w = ADDRESS + 1;
  localparam fifo_flags_t c_flags_rst = '{full: 1'b0, empty: 1'b1,
                                          almost_full: 1'b0, almost_empty: 1'b1};

  logic [c_ptr_w-1:0] w_wr_ptr;
  logic [c_ptr_w-1:0] w_rd_ptr;
  logic [c_ptr_w-1:0] r_count;
  logic [c_ptr_w-1:0] w_count_nxt;
  fifo_flags_t        r_flags;
  fifo_flags_t        w_flags_nxt;
  logic               w_push_acc;
  logic               w_pop_acc;
  logic               r_pop_valid;
  logic [WIDTH-1:0]   w_rd_data;
  logic               w_unused_wrap;

  // Acceptance uses only registered flags, so push/pop never reach the flags combinationally.
  assign w_push_acc  = bus.push & ~r_flags.full;
  assign w_pop_acc   = bus.pop  & ~r_flags.empty;
  assign w_count_nxt = c_ptr_w'(next_count(32'(r_count), w_push_acc, w_pop_acc));

  fifo_ptr #(.W(c_ptr_w)) u_wr_ptr (
    .clk   (clock),
    .rst   (reset),
    .i_en  (w_push_acc),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.W(c_ptr_w)) u_rd_ptr (
    .clk   (clock),
    .rst   (reset),
    .i_en  (w_pop_acc),
    .o_ptr (w_rd_ptr)
  );

  // The wrap bits only matter for the counters themselves; the RAM sees the low bits.
  assign w_unused_wrap = w_wr_ptr[ADDRESS] ^ w_rd_ptr[ADDRESS];

  always_comb begin
    w_flags_nxt              = c_flags_rst;
    w_flags_nxt.full         = (w_count_nxt == c_ptr_w'(DEPTH));
    w_flags_nxt.empty        = (w_count_nxt == '0);
    w_flags_nxt.almost_full  = (w_count_nxt >= c_ptr_w'(AF_LEVEL));
    w_flags_nxt.almost_empty = (w_count_nxt <= c_ptr_w'(AE_LEVEL));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_flags     <= c_flags_rst;
      r_pop_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_flags     <= w_flags_nxt;
      r_pop_valid <= w_pop_acc;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.push & r_flags.full)  r_overflow  <= 1'b1;
      if (bus.pop  & r_flags.empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

  assign w_rd_data        = bus.ram_rd_data;
  assign bus.pop_data     = w_rd_data;
  assign bus.pop_valid    = r_pop_valid;
  assign bus.push_ready   = ~r_flags.full;
  assign bus.full         = r_flags.full;
  assign bus.empty        = r_flags.empty;
  assign bus.almost_full  = r_flags.almost_full;
  assign bus.almost_empty = r_flags.almost_empty;
  assign bus.count        = r_count;
  assign bus.ram_wr_en    = w_push_acc;
  assign bus.ram_wr_addr  = w_wr_ptr[ADDRESS-1:0];
  assign bus.ram_wr_data  = bus.push_data;
  assign bus.ram_rd_en    = w_pop_acc;
  assign bus.ram_rd_addr  = w_rd_ptr[ADDRESS-1:0];

endmodule
`default_nettype wire

// File: doc/fifo_ctrl_dp.md
Name: fifo_ctrl_dp

Overview:
- Synchronous FIFO controller placed directly upstream of ram_dp_sync.
- Converts a push/pop stream interface into the RAM's write port (wr_en/wr_addr/data_in) and read port (rd_en/rd_addr/data_out).
- Owns read/write pointers, occupancy count and status flags; returns RAM read data to the consumer with a valid strobe.
- One instance plus one ram_dp_sync forms the lab FIFO.

Parameters:
- WIDTH, 8, data width; must match the RAM's WIDTH.
- DEPTH, 16, number of entries; must equal 2**ADDRESS.
- ADDRESS, 4, RAM address width.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- push  in  1  producer write request.
- push_data  in  WIDTH  write data.
- push_ready  out  1  equals !full.
- pop  in  1  consumer read request.
- pop_data  out  WIDTH  read data; equals ram_rd_data.
- pop_valid  out  1  pop_data is valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDRESS+1  occupancy, 0..DEPTH.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDRESS  to RAM wr_addr.
- ram_wr_data  out  WIDTH  to RAM data_in.
- ram_rd_en  out  1  to RAM rd_en.
- ram_rd_addr  out  ADDRESS  to RAM rd_addr.
- ram_rd_data  in  WIDTH  from RAM data_out (registered, 1-cycle latency).

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - pop_valid = 0, push_ready = 1.
- Reset mid-operation discards all stored entries; RAM contents are not cleared but become unreachable.
- Pointers are ADDRESS+1 bits: the low ADDRESS bits are the RAM address, the MSB is the wrap bit. Both increment modulo 2*DEPTH.
- push_acc = push & !full; pop_acc = pop & !empty. Both use registered flags from the previous edge.
- ram_wr_en = push_acc, ram_wr_addr = wr_ptr[ADDRESS-1:0], ram_wr_data = push_data. These are combinational; the RAM captures them on the same edge.
- ram_rd_en = pop_acc, ram_rd_addr = rd_ptr[ADDRESS-1:0]. These are combinational.
- On each edge:
  - wr_ptr += push_acc; rd_ptr += pop_acc.
  - count += push_acc - pop_acc.
  - All flags are registered from the next count value, so there is no combinational path from push/pop to the flags.
- pop_valid is a register set to pop_acc. pop_data appears exactly 1 cycle after the accepted pop, aligned with the RAM's registered output.
- push & pop together:
  - Neither blocked: both accepted, count unchanged.
  - At full: only the pop is accepted; count decrements; push_data is dropped.
  - At empty: only the push is accepted. There is no write-through bypass; the data is readable from the next cycle.
- Read/write address collision cannot occur: equal addresses imply full (push blocked) or empty (pop blocked).
- Push while full or pop while empty is ignored: no pointer change, no RAM strobe.
- Wrap: after 16 accepted pushes from reset, wr_ptr = 5'b10000 and ram_wr_addr = 0.

Optional Feature:
- Macro FIFO_ERR_FLAG_EN.
- When defined, adds two outputs, overflow and underflow, each 1 bit.
  - overflow sets on push & full; underflow sets on pop & empty.
  - Both are sticky until reset and reset to 0.
- When undefined, neither port exists and the block's behaviour is otherwise identical.

Decomposition:
- Package fifo_pkg holds:
  - localparams FIFO_WIDTH = 8, FIFO_DEPTH = 16, FIFO_ADDRESS = 4 as defaults;
  - a derived pointer-width constant (ADDRESS+1);
  - a helper function for the next count value.
- One sub-module, fifo_ptr: an ADDRESS+1-bit wrap counter with increment enable and async reset. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Fill/drain: push 0..15 on consecutive cycles → full = 1 and count = 16 after the 16th edge. Then pop 16 → pop_data sequence 0..15, each one cycle after its pop; empty = 1 at the end.
- Overflow: at full, push 8'hAA → no ram_wr_en, count stays 16, overflow = 1 if FIFO_ERR_FLAG_EN. Subsequent drain returns no 8'hAA.
- Simultaneous: with count = 5, push 8'h3C & pop together for 4 cycles → count stays 5; pop_data follows FIFO order.
- Empty push & pop: at count = 0, assert both with 8'h11 → only the push is accepted, pop_valid = 0, count = 1. The next pop returns 8'h11.
- Thresholds/wrap:
  - push 12 → almost_full rises on the 12th edge;
  - pop 10 → almost_empty rises when count = 2;
  - then push 14 more → ram_wr_addr wraps 15→0, data intact.
- Reset mid-operation: at count = 7 with pop active, pulse reset asynchronously between edges → flags and count go to reset values immediately and pop_valid = 0. Next push 8'h5A then pop returns 8'h5A.
